binary_morph: RTL and testbench

Parametrised binary morphology filter for the thresholded video stream. It performs erosion or dilation over a square KSIZE×KSIZE window, with KSIZE of 3 or 5. It sits between the threshold stage and downstream blob/overlay logic in the OV5640→SDRAM→LCD path. It owns its line buffers, so no vendor shift-register IP is needed. It masks out-of-frame taps so frame edges are not corrupted by stale or previous-frame data.

---
 rtl/morph_pkg.sv | 20 ++
 rtl/morph_line_buf.sv | 32 +++
 rtl/binary_morph.sv | 169 ++++++++++++++++
 tb/tb_binary_morph.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/morph_pkg.sv
// Shared constants and helpers for the binary morphology filter.
// Optional dilate support is enabled with MORPH_DILATE_EN.
package morph_pkg;

  localparam logic MORPH_ERODE  = 1'b0;
  localparam logic MORPH_DILATE = 1'b1;
  localparam int   MORPH_LAT    = 3;

  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } morph_sync_t;

  // Value that leaves the reduction unchanged: 1 for AND, 0 for OR.
  function automatic logic neutral(input logic mode);
    return (mode == MORPH_ERODE);
  endfunction

endpackage

// File: rtl/morph_line_buf.sv
// Single-line 1-bit RAM, asynchronous read, read-before-write.
// Addresses past DEPTH are ignored on write and read as 0.
module morph_line_buf #(
  parameter int DEPTH = 800,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          din,
  output logic          dout
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  logic          r_mem [DEPTH];
  logic          w_hit;
  logic [IW-1:0] w_idx;

  assign w_hit = ({1'b0, addr} < LIM);
  assign w_idx = addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (we && w_hit) begin
      r_mem[w_idx] <= din;
    end
  end

  assign dout = w_hit ? r_mem[w_idx] : 1'b0;

endmodule

// File: rtl/binary_morph.sv
// KSIZE x KSIZE binary erode/dilate filter, 3-clock latency.
// Define MORPH_DILATE_EN to make the mode port functional.
module binary_morph
  import morph_pkg::*;
#(
  parameter int IMG_W  = 800,
  parameter int KSIZE  = 3,
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic in_vs,
  input  logic in_hs,
  input  logic in_de,
  input  logic in_data,
  output logic out_vs,
  output logic out_hs,
  output logic out_de,
  output logic out_data
);

  localparam int RW = $clog2(KSIZE);
  localparam logic [RW-1:0] ROW_MAX = RW'(KSIZE-1);

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("binary_morph: KSIZE must be 3 or 5");
  end
  if ((2**ADDR_W) < IMG_W) begin : g_bad_addr_w
    $error("binary_morph: ADDR_W too small for IMG_W");
  end

  logic [ADDR_W-1:0] r_col;
  logic [RW-1:0]     r_row;
  logic              r_vs_d;
  logic              r_de_d;
  logic              w_vs_rise;
  logic              w_de_fall;
  logic              w_n;

  logic [KSIZE-2:0]  w_buf_q;
  logic [KSIZE-1:0]  w_tap;
  logic [KSIZE-1:0]  r_win [KSIZE];
  logic [KSIZE-1:0]  w_rowred;
  logic [KSIZE-1:0]  r_rowred;
  logic              w_final;
  logic              r_res;
  morph_sync_t       r_sync [MORPH_LAT];

  assign w_vs_rise = in_vs & ~r_vs_d;
  assign w_de_fall = r_de_d & ~in_de;

`ifdef MORPH_DILATE_EN
  logic r_mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_q <= MORPH_ERODE;
    end else if (w_vs_rise) begin
      r_mode_q <= mode;
    end
  end

  assign w_n = neutral(r_mode_q);
`else
  logic w_unused_mode;

  assign w_unused_mode = mode;
  assign w_n = neutral(MORPH_ERODE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
    end else begin
      r_vs_d <= in_vs;
      r_de_d <= in_de;
      r_col  <= in_de ? r_col + 1'b1 : '0;
      if (w_vs_rise) begin
        r_row <= '0;
      end else if (w_de_fall && r_row != ROW_MAX) begin
        r_row <= r_row + 1'b1;
      end
    end
  end

  // Buffer k holds row r-1-k; rows not yet seen this frame read as N.
  for (genvar k = 0; k < KSIZE-1; k++) begin : g_lb
    logic w_din;

    if (k == 0) begin : g_first
      assign w_din = in_data;
    end else begin : g_chain
      assign w_din = w_buf_q[k-1];
    end

    morph_line_buf #(
      .DEPTH (IMG_W),
      .AW    (ADDR_W)
    ) u_lb (
      .clk  (clk),
      .we   (in_de),
      .addr (r_col),
      .din  (w_din),
      .dout (w_buf_q[k])
    );

    assign w_tap[k+1] = (r_row <= RW'(k)) ? w_n : w_buf_q[k];
  end

  assign w_tap[0] = in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < KSIZE; j++) begin
        r_win[j] <= '0;
      end
    end else begin
      for (int j = 0; j < KSIZE; j++) begin
        if (in_de) begin
          r_win[j] <= {r_win[j][KSIZE-2:0], w_tap[j]};
        end else begin
          r_win[j] <= {KSIZE{w_n}};
        end
      end
    end
  end

  always_comb begin
    w_final = &r_rowred;
    for (int j = 0; j < KSIZE; j++) begin
      w_rowred[j] = &r_win[j];
    end
`ifdef MORPH_DILATE_EN
    if (r_mode_q == MORPH_DILATE) begin
      w_final = |r_rowred;
      for (int j = 0; j < KSIZE; j++) begin
        w_rowred[j] = |r_win[j];
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rowred <= '0;
      r_res    <= 1'b0;
      for (int i = 0; i < MORPH_LAT; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_rowred  <= w_rowred;
      r_res     <= w_final;
      r_sync[0] <= '{vs: in_vs, hs: in_hs, de: in_de};
      for (int i = 1; i < MORPH_LAT; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign out_vs   = r_sync[MORPH_LAT-1].vs;
  assign out_hs   = r_sync[MORPH_LAT-1].hs;
  assign out_de   = r_sync[MORPH_LAT-1].de;
  assign out_data = r_sync[MORPH_LAT-1].de & r_res;

endmodule

// File: tb/tb_binary_morph.sv
// Bench for binary_morph: KSIZE 3 and 5 instances on one stream,
// checked every cycle against a window-reduction model.
module tb_binary_morph;

  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic in_vs = 1'b0;
  logic in_hs = 1'b0;
  logic in_de = 1'b0;
  logic in_data = 1'b0;

  logic o3_vs, o3_hs, o3_de, o3_d;
  logic o5_vs, o5_hs, o5_de, o5_d;

  int errors = 0;
  int checks = 0;

  logic       fr [H][W];
  logic       q3 [$];
  logic       q5 [$];
  logic [2:0] hist [3];

  always #5 clk = ~clk;

  binary_morph #(
    .IMG_W(W), .KSIZE(3), .ADDR_W(4)
  ) u3 (
    .clk(clk), .rst(rst), .mode(mode),
    .in_vs(in_vs), .in_hs(in_hs),
    .in_de(in_de), .in_data(in_data),
    .out_vs(o3_vs), .out_hs(o3_hs),
    .out_de(o3_de), .out_data(o3_d)
  );

  binary_morph #(
    .IMG_W(W), .KSIZE(5), .ADDR_W(4)
  ) u5 (
    .clk(clk), .rst(rst), .mode(mode),
    .in_vs(in_vs), .in_hs(in_hs),
    .in_de(in_de), .in_data(in_data),
    .out_vs(o5_vs), .out_hs(o5_hs),
    .out_de(o5_de), .out_data(o5_d)
  );

  task automatic chk(input string name,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reduction over the KxK window ending at (r,c); off-frame taps are N.
  function automatic logic model_px(int k, logic m, int r, int c);
    logic n, acc, v;
    n = ~m;
    acc = n;
    for (int rr = r-k+1; rr <= r; rr++) begin
      for (int cc = c-k+1; cc <= c; cc++) begin
        v = (rr < 0 || cc < 0) ? n : fr[rr][cc];
        acc = m ? (acc | v) : (acc & v);
      end
    end
    return acc;
  endfunction

  function automatic logic eff_mode(logic m);
`ifdef MORPH_DILATE_EN
    return m;
`else
    return 1'b0;
`endif
  endfunction

  task automatic fill_const(logic v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = v;
  endtask

  task automatic fill_rand(int p1);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = ($urandom_range(0, 99) < p1);
  endtask

  task automatic step(logic vs, logic hs, logic de, logic d);
    in_vs = vs;
    in_hs = hs;
    in_de = de;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(logic m, logic toggle, logic abort);
    logic fm;
    fm = eff_mode(m);
    mode = m;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int r = 0; r < H; r++) begin
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      if (toggle && r == 2) mode = ~m;
      for (int c = 0; c < W; c++) begin
        if (abort && r == 3 && c == 4) begin
          in_vs = 0; in_hs = 0;
          in_de = 0; in_data = 0;
          rst = 1'b1;
          @(posedge clk);
          @(posedge clk);
          #1;
          rst = 1'b0;
          return;
        end
        q3.push_back(model_px(3, fm, r, c));
        q5.push_back(model_px(5, fm, r, c));
        step(0, 0, 1, fr[r][c]);
      end
    end
    repeat (3) step(0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    logic e;
    if (rst) begin
      chk("reset_k3", {o3_vs, o3_hs, o3_de, o3_d}, 4'h0);
      chk("reset_k5", {o5_vs, o5_hs, o5_de, o5_d}, 4'h0);
      for (int i = 0; i < 3; i++) hist[i] = 3'b000;
      q3.delete();
      q5.delete();
    end else begin
      chk("sync_k3", {1'b0, o3_vs, o3_hs, o3_de}, {1'b0, hist[2]});
      chk("sync_k5", {1'b0, o5_vs, o5_hs, o5_de}, {1'b0, hist[2]});
      if (hist[2][0]) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL underflow_k3: got pixel want none at %0t", $time);
        end else begin
          e = q3.pop_front();
          chk("data_k3", {3'b0, o3_d}, {3'b0, e});
        end
        if (q5.size() == 0) begin
          checks++; errors++;
          $display("FAIL underflow_k5: got pixel want none at %0t", $time);
        end else begin
          e = q5.pop_front();
          chk("data_k5", {3'b0, o5_d}, {3'b0, e});
        end
      end else begin
        chk("blank_k3", {3'b0, o3_d}, 4'h0);
        chk("blank_k5", {3'b0, o5_d}, 4'h0);
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {in_vs, in_hs, in_de};
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) step(0, 0, 0, 0);

    fill_const(1'b1);
    fr[2][3] = 1'b0;
    chk("model_e3_23", {3'b0, model_px(3, 0, 2, 3)}, 4'h0);
    chk("model_e3_45", {3'b0, model_px(3, 0, 4, 5)}, 4'h0);
    chk("model_e3_46", {3'b0, model_px(3, 0, 4, 6)}, 4'h1);
    chk("model_e3_53", {3'b0, model_px(3, 0, 5, 3)}, 4'h1);
    chk("model_e3_13", {3'b0, model_px(3, 0, 1, 3)}, 4'h1);
    fill_const(1'b1);
    fr[0][0] = 1'b0;
    chk("model_e5_44", {3'b0, model_px(5, 0, 4, 4)}, 4'h0);
    chk("model_e5_05", {3'b0, model_px(5, 0, 0, 5)}, 4'h1);
    chk("model_e5_50", {3'b0, model_px(5, 0, 5, 0)}, 4'h1);
    fill_const(1'b0);
    fr[1][1] = 1'b1;
    chk("model_d3_33", {3'b0, model_px(3, 1, 3, 3)}, 4'h1);
    chk("model_d3_01", {3'b0, model_px(3, 1, 0, 1)}, 4'h0);
    chk("model_d3_14", {3'b0, model_px(3, 1, 1, 4)}, 4'h0);

    fill_const(1'b1);
    drive_frame(0, 0, 0);
    fr[2][3] = 1'b0;
    drive_frame(0, 0, 0);
    fill_const(1'b0);
    fr[1][1] = 1'b1;
    drive_frame(1, 0, 0);
    fill_const(1'b1);
    fr[0][0] = 1'b0;
    drive_frame(0, 0, 0);

    fill_rand(50);
    drive_frame(0, 1, 0);
    fill_rand(15);
    drive_frame(1, 0, 0);

    fill_rand(85);
    drive_frame(0, 0, 1);
    repeat (4) step(0, 0, 0, 0);
    drive_frame(0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      logic m;
      m = 1'($urandom_range(0, 1));
      fill_rand(m ? 12 : 88);
      drive_frame(m, 0, 0);
    end

    repeat (8) step(0, 0, 0, 0);
    chk("drain_k3", 4'(q3.size()), 4'h0);
    chk("drain_k5", 4'(q5.size()), 4'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
